i2s_frame_ctrl: RTL and testbench

I2S master frame controller running directly on the 48 MHz HSOSC clock. Generates a 1.536 MHz BCLK with a fractional 31.25-cycle average period and a 48 kHz word-select. Serialises a stereo 16-bit playback pair to the codec/DAC and deserialises a stereo 16-bit capture pair from the microphone ADC. Sits between the audio sample pipeline (valid/ready source, valid-pulse sink) and the I2S pins. All pin timing is derived from clk_48mhz enables; there is no second clock domain.

---
 rtl/i2s_frame_ctrl.sv | 133 +++++++++++++
 tb/tb_i2s_frame_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_ctrl.sv
// I2S master frame controller: 32 slots/frame, 31/32-cycle slots (1000 cycles/frame),
// Philips one-slot delay, stereo 16-bit playback and capture on the 48 MHz clock.
module i2s_frame_ctrl (
  input  logic        clk_48mhz,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] tx_left,
  input  logic [15:0] tx_right,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_underrun,
  output logic [15:0] rx_left,
  output logic [15:0] rx_right,
  output logic        rx_valid,
  output logic        bclk,
  output logic        ws,
  output logic        sdout,
  input  logic        sdin,
  output logic        running
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [4:0]  slot, slot_nxt;
  logic [4:0]  phase, phase_nxt;
  logic        slot_end;
  logic        frame_end;
  logic [3:0]  bit_idx;
  logic        tx_bit;
  logic [15:0] tx_l_q, tx_r_q;
  logic [15:0] rx_l_sr, rx_r_sr;
  logic        primed;

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      state <= IDLE;
      slot  <= '0;
      phase <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = '0;
    phase_nxt = '0;
    slot_end  = (phase == ((slot[1:0] == 2'd3) ? 5'd31 : 5'd30));
    frame_end = slot_end && (slot == 5'd31);
    case (state)
      IDLE: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (slot_end) begin
          slot_nxt = slot + 5'd1;
          if (frame_end && !en) state_nxt = IDLE;
        end else begin
          slot_nxt  = slot;
          phase_nxt = phase + 5'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slot k maps to bit (16-k) of left or (32-k) of right; both reduce to -k mod 16.
  always_comb begin
    bit_idx = 4'd0 - slot[3:0];
    if (slot == 5'd0)       tx_bit = tx_r_q[0];
    else if (slot <= 5'd16) tx_bit = tx_l_q[bit_idx];
    else                    tx_bit = tx_r_q[bit_idx];
  end

  // Pins are registered from the counters, so they trail the counter state by one cycle.
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      running  <= 1'b0;
      tx_ready <= 1'b0;
      bclk     <= 1'b0;
      ws       <= 1'b0;
      sdout    <= 1'b0;
      tx_l_q   <= '0;
      tx_r_q   <= '0;
      rx_l_sr  <= '0;
      rx_r_sr  <= '0;
      rx_left  <= '0;
      rx_right <= '0;
      rx_valid <= 1'b0;
      primed   <= 1'b0;
    end else begin
      running  <= (state == RUN);
      tx_ready <= (state == RUN) && (slot == 5'd0) && (phase == 5'd0);
      bclk     <= (state == RUN) && phase[4];
      ws       <= (state == RUN) && slot[4];
      rx_valid <= 1'b0;

      if (state != RUN)        sdout <= 1'b0;
      else if (phase == 5'd0)  sdout <= tx_bit;

      if (state == IDLE) begin
        tx_l_q <= '0;
        tx_r_q <= '0;
      end else if (tx_ready) begin
        tx_l_q <= tx_valid ? tx_left  : '0;
        tx_r_q <= tx_valid ? tx_right : '0;
      end

      if (state == IDLE) begin
        rx_l_sr <= '0;
        rx_r_sr <= '0;
        primed  <= 1'b0;
      end else if (phase == 5'd17) begin
        if (slot >= 5'd1 && slot <= 5'd16) rx_l_sr <= {rx_l_sr[14:0], sdin};
        else                               rx_r_sr <= {rx_r_sr[14:0], sdin};
        if (slot == 5'd0) begin
          primed <= 1'b1;
          if (primed) begin
            rx_left  <= rx_l_sr;
            rx_right <= {rx_r_sr[14:0], sdin};
            rx_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign tx_underrun = tx_ready & ~tx_valid;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Self-checking bench for i2s_frame_ctrl: per-cycle reference model derived from
// frame arithmetic (slot lengths, bit mapping), loopback capture, randomized data.
module tb_i2s_frame_ctrl;

  logic        clk_48mhz = 1'b0;
  logic        reset_n, en, tx_valid, sdin;
  logic [15:0] tx_left, tx_right;
  logic        tx_ready, tx_underrun, rx_valid, bclk, ws, sdout, running;
  logic [15:0] rx_left, rx_right;

  int vectors = 0;
  int miscompares = 0;
  int nprint = 0;

  logic [15:0] exp_rx_l = '0, exp_rx_r = '0;
  logic        pb = 1'b0, pw = 1'b0;
  logic [15:0] fl [0:15];
  logic [15:0] fr [0:15];
  bit          fv [0:15];

  i2s_frame_ctrl dut (
    .clk_48mhz  (clk_48mhz),
    .reset_n    (reset_n),
    .en         (en),
    .tx_left    (tx_left),
    .tx_right   (tx_right),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .rx_left    (rx_left),
    .rx_right   (rx_right),
    .rx_valid   (rx_valid),
    .bclk       (bclk),
    .ws         (ws),
    .sdout      (sdout),
    .sdin       (sdin),
    .running    (running)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  function automatic int slot_len(input int k);
    return ((k % 4) == 3) ? 32 : 31;
  endfunction

  function automatic void slot_of(input int r_in, output int k, output int p);
    int r;
    r = r_in;
    k = 0;
    while (r >= slot_len(k)) begin
      r -= slot_len(k);
      k++;
    end
    p = r;
  endfunction

  task automatic check_all_zero(input string name);
    vectors++;
    if ({bclk, ws, sdout, tx_ready, tx_underrun, running, rx_valid} !== 7'b0 ||
        rx_left !== 16'h0 || rx_right !== 16'h0) begin
      miscompares++;
      $display("FAIL %s zero_outputs got pins=%b rxl=%h rxr=%h exp all 0", name,
               {bclk, ws, sdout, tx_ready, tx_underrun, running, rx_valid}, rx_left, rx_right);
    end
  endtask

  // Runs nframes frames (drops en at drop_slot of the last one), optional underrun frame,
  // optional en glitch frame, optional reset at slot 20 p 18 of reset_f.
  task automatic run_case(input string name, input int nframes, input int underrun_f,
                          input int glitch_f, input int drop_slot, input int reset_f,
                          input bit fixed);
    int t, f, r, k, p, total, last_rise, last_rdy;
    bit stop;
    logic [15:0] sl, sr, prev_sr;
    logic e_sd, e_rxv;
    logic [6:0] got, exp;
    for (int i = 0; i < nframes; i++) begin
      fl[i] = fixed ? 16'hA5C3 : 16'($urandom);
      fr[i] = fixed ? 16'h0F01 : 16'($urandom);
      fv[i] = (i != underrun_f);
    end
    total = nframes * 1000;
    last_rise = -1;
    last_rdy = -1;
    @(negedge clk_48mhz);
    en = 1'b1;
    @(negedge clk_48mhz);
    vectors++;
    if (running !== 1'b0 || tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s start_latency running=%b tx_ready=%b exp 0 0", name, running, tx_ready);
    end
    t = 0;
    stop = 0;
    while (!stop) begin
      @(negedge clk_48mhz);
      e_rxv = 1'b0;
      if (t < total) begin
        f = t / 1000;
        r = t % 1000;
        slot_of(r, k, p);
        if (r == 0) begin
          tx_left  = fl[f];
          tx_right = fr[f];
          tx_valid = fv[f];
        end
        if (f == nframes - 1 && k == drop_slot && p == 0) en = 1'b0;
        if (f == glitch_f && k == 3 && p == 0) en = 1'b0;
        if (f == glitch_f && k == 10 && p == 0) en = 1'b1;
        sl = fv[f] ? fl[f] : 16'h0;
        sr = fv[f] ? fr[f] : 16'h0;
        prev_sr = (f == 0) ? 16'h0 : (fv[f-1] ? fr[f-1] : 16'h0);
        if (k == 0)       e_sd = prev_sr[0];
        else if (k <= 16) e_sd = sl[16-k];
        else              e_sd = sr[32-k];
        if (k == 0 && p == 17 && f >= 1) begin
          e_rxv = 1'b1;
          exp_rx_l = fv[f-1] ? fl[f-1] : 16'h0;
          exp_rx_r = prev_sr;
        end
        exp = {p >= 16, k >= 16, e_sd, r == 0, (r == 0) && !tx_valid, 1'b1, e_rxv};
      end else begin
        exp = 7'b0;
        if (t >= total + 60) stop = 1;
      end
      sdin = sdout;
      #1;
      got = {bclk, ws, sdout, tx_ready, tx_underrun, running, rx_valid};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        if (nprint++ < 30)
          $display("FAIL %s pins t=%0d got bclk,ws,sd,rdy,unr,run,rxv=%b exp=%b", name, t, got, exp);
      end
      vectors++;
      if (rx_left !== exp_rx_l || rx_right !== exp_rx_r) begin
        miscompares++;
        if (nprint++ < 30)
          $display("FAIL %s rx_data t=%0d got %h/%h exp %h/%h", name, t, rx_left, rx_right,
                   exp_rx_l, exp_rx_r);
      end
      if (bclk === 1'b1 && pb === 1'b0 && t < total) begin
        if (last_rise >= 0) begin
          vectors++;
          if (t - last_rise !== slot_len((k + 31) % 32)) begin
            miscompares++;
            $display("FAIL %s bclk_period t=%0d got %0d exp %0d", name, t, t - last_rise,
                     slot_len((k + 31) % 32));
          end
        end
        last_rise = t;
      end
      if (tx_ready === 1'b1) begin
        if (last_rdy >= 0) begin
          vectors++;
          if (t - last_rdy !== 1000) begin
            miscompares++;
            $display("FAIL %s ready_interval got %0d exp 1000", name, t - last_rdy);
          end
        end
        last_rdy = t;
      end
      if (ws !== pw) begin
        vectors++;
        if (!(pb === 1'b1 && bclk === 1'b0)) begin
          miscompares++;
          $display("FAIL %s ws_edge t=%0d ws=%b bclk %b->%b exp bclk falling", name, t, ws, pb, bclk);
        end
      end
      pb = bclk;
      pw = ws;
      if (reset_f >= 0 && t < total && f == reset_f && k == 20 && p == 18) begin
        reset_n = 1'b0;
        @(negedge clk_48mhz);
        #1;
        exp_rx_l = '0;
        exp_rx_r = '0;
        check_all_zero({name, "_reset"});
        pb = bclk;
        pw = ws;
        reset_n = 1'b1;
        en = 1'b0;
        stop = 1;
      end
      t++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en = 1'b0;
    tx_valid = 1'b0;
    tx_left = '0;
    tx_right = '0;
    sdin = 1'b0;
    repeat (3) @(negedge clk_48mhz);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
  endtask

  task automatic test_basic();      run_case("basic", 3, -1, -1, 5, -1, 1'b1);  endtask
  task automatic test_loopback();   run_case("loopback", 4, -1, -1, 20, -1, 1'b0); endtask
  task automatic test_underrun();   run_case("underrun", 3, 1, -1, 5, -1, 1'b0); endtask
  task automatic test_en_drop();    run_case("en_drop", 2, -1, -1, 5, -1, 1'b0); endtask
  task automatic test_reset_mid();  run_case("reset_mid", 2, -1, -1, 5, 1, 1'b0); endtask
  task automatic test_restart();    run_case("restart", 2, -1, -1, 5, -1, 1'b1); endtask
  task automatic test_ws_frames();  run_case("ws_frames", 10, -1, 4, 7, -1, 1'b0); endtask

  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_underrun();
    test_en_drop();
    test_reset_mid();
    test_restart();
    test_ws_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
